// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: classifies the executed instruction, resolves
// branches, and buffers results in a main register plus a one-entry skid
// register so upstream sees a registered ready.
module ex_mem_stage #(
  parameter int unsigned RSTATUS_REG = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [4:0]  in_aluop,
  input  logic [4:0]  in_rd,
  input  logic [31:0] alu_result,
  input  logic        alu_isNotEqual,
  input  logic        alu_isLessThan,
  input  logic        alu_overflow,
  input  logic [31:0] in_target,
  input  logic [31:0] in_store_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [31:0] out_store_data,
  output logic        out_is_store,
  output logic        out_is_load,
  output logic        branch_taken,
  output logic [31:0] branch_target
);

  typedef enum logic [4:0] {
    OP_ALU  = 5'b00000,
    OP_BNE  = 5'b00010,
    OP_ADDI = 5'b00101,
    OP_BLT  = 5'b00110,
    OP_SW   = 5'b00111,
    OP_LW   = 5'b01000
  } opcode_e;

  localparam logic [4:0] ALUOP_ADD = 5'b00000;
  localparam logic [4:0] ALUOP_SUB = 5'b00001;
  localparam logic [4:0] RSTATUS   = 5'(RSTATUS_REG);

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] store_data;
    logic        is_store;
    logic        is_load;
  } entry_t;

  entry_t      main_q, main_d, skid_q, skid_d, incoming;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_d;
  logic        taken_d;
  logic [31:0] target_d;
  logic        take;
  logic        accept;
  logic        we_base;

  // Decode the presented instruction into an output entry and branch decision
  always_comb begin
    incoming            = '0;
    incoming.result     = alu_result;
    incoming.rd         = in_rd;
    incoming.store_data = in_store_data;
    incoming.is_store   = (in_opcode == OP_SW);
    incoming.is_load    = (in_opcode == OP_LW);
    we_base = (in_opcode == OP_ALU) || (in_opcode == OP_ADDI) || (in_opcode == OP_LW);
    if (alu_overflow) begin
      if (in_opcode == OP_ALU && in_aluop == ALUOP_ADD) begin
        incoming.result = 32'd1;
        incoming.rd     = RSTATUS;
        we_base         = 1'b1;
      end else if (in_opcode == OP_ADDI) begin
        incoming.result = 32'd2;
        incoming.rd     = RSTATUS;
        we_base         = 1'b1;
      end else if (in_opcode == OP_ALU && in_aluop == ALUOP_SUB) begin
        incoming.result = 32'd3;
        incoming.rd     = RSTATUS;
        we_base         = 1'b1;
      end
    end
    incoming.we = we_base && (incoming.rd != '0);
    take = ((in_opcode == OP_BNE) && alu_isNotEqual) ||
           ((in_opcode == OP_BLT) && alu_isLessThan);
  end

  // Main/skid occupancy and branch pulse next-state
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    taken_d      = 1'b0;
    target_d     = branch_target;
    accept       = in_valid && in_ready && !flush;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (accept && take) begin
        taken_d  = 1'b1;
        target_d = in_target;
      end
      if (!main_valid_q || out_ready) begin
        // skid is only ever full while in_ready=0, so it never competes with accept
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d       = incoming;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = incoming;
        skid_valid_d = 1'b1;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      main_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
      in_ready      <= 1'b1;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      main_q        <= main_d;
      main_valid_q  <= main_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      in_ready      <= in_ready_d;
      branch_taken  <= taken_d;
      branch_target <= target_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_result     = main_q.result;
  assign out_rd         = main_q.rd;
  assign out_we         = main_q.we;
  assign out_store_data = main_q.store_data;
  assign out_is_store   = main_q.is_store;
  assign out_is_load    = main_q.is_load;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes hand-computed entries,
// a negedge monitor pops and compares on every output transfer.
module tb_ex_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode, in_aluop, in_rd;
  logic [31:0] alu_result;
  logic        alu_isNotEqual, alu_isLessThan, alu_overflow;
  logic [31:0] in_target, in_store_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [31:0] out_store_data;
  logic        out_is_store, out_is_load;
  logic        branch_taken;
  logic [31:0] branch_target;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] sd;
    logic        st;
    logic        ld;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_mem_stage #(.RSTATUS_REG(30)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_aluop(in_aluop), .in_rd(in_rd),
    .alu_result(alu_result), .alu_isNotEqual(alu_isNotEqual),
    .alu_isLessThan(alu_isLessThan), .alu_overflow(alu_overflow),
    .in_target(in_target), .in_store_data(in_store_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .out_store_data(out_store_data), .out_is_store(out_is_store),
    .out_is_load(out_is_load),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [4:0] d, input logic w,
                              input logic [31:0] s, input logic st, input logic ld);
    exp_t e;
    e.result = r; e.rd = d; e.we = w; e.sd = s; e.st = st; e.ld = ld;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] aop,
                       input logic [4:0] rd, input logic [31:0] res, input logic ne,
                       input logic lt, input logic ov, input logic [31:0] tgt,
                       input logic [31:0] sd);
    in_valid = v; in_opcode = op; in_aluop = aop; in_rd = rd; alu_result = res;
    alu_isNotEqual = ne; alu_isLessThan = lt; alu_overflow = ov;
    in_target = tgt; in_store_data = sd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Drive one instruction for one cycle and record what must come out
  task automatic send(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] rd,
                      input logic [31:0] res, input logic ne, input logic lt,
                      input logic ov, input logic [31:0] tgt, input logic [31:0] sd,
                      input exp_t e);
    exp_q.push_back(e);
    drive(1'b1, op, aop, rd, res, ne, lt, ov, tgt, sd);
    step();
  endtask

  // Monitor: every transfer must match the oldest expected entry
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got result=%h rd=%0d expected no transfer", out_result, out_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_result", out_result, e.result);
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("out_we", 32'(out_we), 32'(e.we));
        chk("out_store_data", out_store_data, e.sd);
        chk("out_is_store", 32'(out_is_store), 32'(e.st));
        chk("out_is_load", 32'(out_is_load), 32'(e.ld));
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle();
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_branch_taken", 32'(branch_taken), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_branch_target", branch_target, 32'd0);
    reset = 1'b1;
    step();

    // Plain add with one-cycle latency, then the overflow and decode cases
    out_ready = 1'b1;
    send(5'd0, 5'd0, 5'd5, 32'h7, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'h7, 5'd5, 1'b1, 32'd0, 1'b0, 1'b0));
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    send(5'd0, 5'd1, 5'd4, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'd0, 32'hAAAA0001, mk(32'd3, 5'd30, 1'b1, 32'hAAAA0001, 1'b0, 1'b0));
    send(5'd5, 5'd0, 5'd6, 32'h0BADF00D, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, mk(32'd2, 5'd30, 1'b1, 32'd0, 1'b0, 1'b0));
    send(5'd0, 5'd0, 5'd8, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, mk(32'd1, 5'd30, 1'b1, 32'd0, 1'b0, 1'b0));
    send(5'd0, 5'd2, 5'd9, 32'h55, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, mk(32'h55, 5'd9, 1'b1, 32'd0, 1'b0, 1'b0));
    send(5'd8, 5'd0, 5'd7, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'h100, 5'd7, 1'b1, 32'd0, 1'b0, 1'b1));
    send(5'd7, 5'd0, 5'd3, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0, 32'hDEADBEEF, mk(32'h200, 5'd3, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0));
    send(5'd5, 5'd0, 5'd0, 32'h9, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'h9, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0));
    send(5'd31, 5'd0, 5'd2, 32'h33, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'h33, 5'd2, 1'b0, 32'd0, 1'b0, 1'b0));
    idle();
    step();

    // Stall: A to main, B to skid, C held off until the pipe drains
    out_ready = 1'b0;
    send(5'd0, 5'd0, 5'd10, 32'hA, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'hA, 5'd10, 1'b1, 32'd0, 1'b0, 1'b0));
    send(5'd0, 5'd0, 5'd11, 32'hB, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'hB, 5'd11, 1'b1, 32'd0, 1'b0, 1'b0));
    chk("skid_full_in_ready", 32'(in_ready), 32'd0);
    exp_q.push_back(mk(32'hC, 5'd12, 1'b1, 32'd0, 1'b0, 1'b0));
    drive(1'b1, 5'd0, 5'd0, 5'd12, 32'hC, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_hold_result", out_result, 32'hA);
    step();
    chk("stall_hold_rd", 32'(out_rd), 32'd10);
    out_ready = 1'b1;
    step();
    chk("skid_drain_in_ready", 32'(in_ready), 32'd1);
    step();
    idle();
    step();

    // Branches: taken blt pulses once, untaken bne stays low, taken bne while stalled
    send(5'd6, 5'd0, 5'd0, 32'h11, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0, mk(32'h11, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0));
    chk("blt_taken", 32'(branch_taken), 32'd1);
    chk("blt_target", branch_target, 32'h40);
    idle();
    step();
    chk("blt_pulse_end", 32'(branch_taken), 32'd0);
    send(5'd2, 5'd0, 5'd1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h80, 32'd0, mk(32'h22, 5'd1, 1'b0, 32'd0, 1'b0, 1'b0));
    chk("bne_not_taken", 32'(branch_taken), 32'd0);
    out_ready = 1'b0;
    idle();
    step();
    send(5'd2, 5'd0, 5'd1, 32'h23, 1'b1, 1'b0, 1'b0, 32'h80, 32'd0, mk(32'h23, 5'd1, 1'b0, 32'd0, 1'b0, 1'b0));
    chk("bne_taken_stalled", 32'(branch_taken), 32'd1);
    chk("bne_target", branch_target, 32'h80);
    idle();
    step();
    chk("bne_pulse_end", 32'(branch_taken), 32'd0);
    out_ready = 1'b1;
    step();
    step();

    // Flush with main and skid both full; inputs during flush are dropped
    out_ready = 1'b0;
    send(5'd0, 5'd0, 5'd13, 32'hD0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'hD0, 5'd13, 1'b1, 32'd0, 1'b0, 1'b0));
    send(5'd0, 5'd0, 5'd14, 32'hD1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'hD1, 5'd14, 1'b1, 32'd0, 1'b0, 1'b0));
    flush = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd15, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    exp_q.delete();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 5'd6, 5'd0, 5'd16, 32'hBEEF, 1'b0, 1'b1, 1'b0, 32'h99, 32'd0);
    step();
    chk("flush_drop_valid", 32'(out_valid), 32'd0);
    chk("flush_drop_branch", 32'(branch_taken), 32'd0);
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    repeat (3) step();

    // Reset in the middle of a full stall, then an add to r0
    out_ready = 1'b0;
    send(5'd0, 5'd0, 5'd17, 32'hE0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1234, mk(32'hE0, 5'd17, 1'b1, 32'h1234, 1'b0, 1'b0));
    send(5'd7, 5'd0, 5'd18, 32'hE1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h5678, mk(32'hE1, 5'd18, 1'b0, 32'h5678, 1'b1, 1'b0));
    reset = 1'b0;
    flush = 1'b1;
    idle();
    step();
    exp_q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_out_store_data", out_store_data, 32'd0);
    chk("midrst_out_is_store", 32'(out_is_store), 32'd0);
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    send(5'd0, 5'd0, 5'd0, 32'h5, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, mk(32'h5, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0));
    chk("rd0_out_we", 32'(out_we), 32'd0);
    idle();

    // Bounded drain of anything still expected
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have parameter RSTATUS_REG, default 30, the register index written on arithmetic overflow.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have ports in_valid input 1, and in_ready output 1, the upstream handshake.
REQ-005 The block SHALL have ports in_opcode input 5, in_aluop input 5 and in_rd input 5, the decoded instruction fields.
REQ-006 The block SHALL have ports alu_result input 32, alu_isNotEqual input 1, alu_isLessThan input 1 and alu_overflow input 1, the ALU outputs for this instruction.
REQ-007 The block SHALL have ports in_target input 32, the branch target, and in_store_data input 32, the sw data.
REQ-008 The block SHALL have port flush, input, 1, which discards all held entries.
REQ-009 The block SHALL have ports out_valid output 1, and out_ready input 1, the downstream handshake.
REQ-010 The block SHALL have ports out_result output 32, out_rd output 5, out_we output 1, out_store_data output 32, out_is_store output 1 and out_is_load output 1.
REQ-011 The block SHALL have ports branch_taken output 1, and branch_target output 32, the registered branch resolution.

Function
REQ-012 The block SHALL accept an input on a cycle with in_valid=1, in_ready=1 and flush=0.
REQ-013 The block SHALL hold state in a main register (drives out_*) and a one-entry skid register.
REQ-014 in_ready SHALL be a registered signal equal to NOT skid_valid.
REQ-015 Acceptance latency SHALL be one cycle: an entry accepted while main is empty, or while main is draining (out_ready=1), appears on out_* on the next cycle.
REQ-016 An entry accepted while out_valid=1 and out_ready=0 SHALL go to skid; in_ready SHALL be 0 on the next cycle.
REQ-017 When out_valid=1, out_ready=1 and skid_valid=1, main SHALL load skid, skid SHALL empty and in_ready SHALL return to 1 on the next cycle.
REQ-018 The out_* outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 Entries SHALL leave in acceptance order; none are dropped or duplicated.
REQ-020 Overflow: if alu_overflow=1 for {opcode 00000, aluop 00000} the entry's result SHALL be 1; for opcode 00101 (addi) it SHALL be 2; for {00000, 00001} (sub) it SHALL be 3; in each case rd SHALL be RSTATUS_REG and we=1.
REQ-021 Otherwise the entry's result SHALL be alu_result and its rd SHALL be in_rd.
REQ-022 we SHALL be 1 for opcodes 00000, 00101 and 01000 (lw), and 0 for all others; we SHALL be forced to 0 when the final rd=0.
REQ-023 out_is_store SHALL be 1 only for opcode 00111; out_is_load SHALL be 1 only for opcode 01000; store_data SHALL be latched with the entry.
REQ-024 Branch: opcode 00010 (bne) SHALL be taken iff alu_isNotEqual=1, and opcode 00110 (blt) SHALL be taken iff alu_isLessThan=1; decisions are computed at acceptance.
REQ-025 branch_taken SHALL pulse high for exactly the cycle after a taken branch is accepted, with branch_target=in_target latched; this is independent of out_ready.
REQ-026 Branch entries SHALL still flow to the output with we=0.
REQ-027 Flush SHALL clear main and skid valid and branch_taken on the next cycle and set in_ready=1; an input presented during flush SHALL be discarded.
REQ-028 If flush and out_ready are both 1, no handshake SHALL count as a transfer beyond the current cycle's out_valid.

Reset
REQ-029 With reset=0 at a clock edge, out_valid, branch_taken and skid_valid SHALL become 0 and in_ready SHALL become 1.
REQ-030 With reset=0 at a clock edge, out_result, out_rd, out_we, out_store_data, out_is_store, out_is_load and branch_target SHALL become 0.
REQ-031 Reset SHALL override flush and any handshake in the same cycle; reset mid-stall SHALL discard both entries.

Verification
REQ-032 The bench SHALL check: add, rd=5, result 0x00000007, out_ready=1 -> next cycle out_valid=1, out_rd=5, out_result=7, out_we=1.
REQ-033 The bench SHALL check: sub with alu_overflow=1, rd=4 -> out_rd=30, out_result=3, out_we=1; addi with overflow -> out_result=2.
REQ-034 The bench SHALL check: out_ready=0 and three back-to-back inputs A,B,C -> A in main, B in skid, in_ready=0, C not accepted; raise out_ready -> A, B, C delivered in order.
REQ-035 The bench SHALL check: blt with alu_isLessThan=1, target 0x40 -> branch_taken=1 for one cycle, branch_target=0x40, out_we=0; bne with isNotEqual=0 -> branch_taken stays 0.
REQ-036 The bench SHALL check: flush while main and skid are both full -> next cycle out_valid=0, in_ready=1; input presented during flush never appears.
REQ-037 The bench SHALL check: reset=0 during a stalled full state -> all outputs 0, in_ready=1; an add with rd=0 afterwards -> out_we=0.
